// File: rtl/hypercpu_mem_arbiter.sv
// hypercpu_mem_arbiter: shares the single hypercpu memory port between the
// instruction fetch (if), load/store (ls) and debug/DMA (dbg) requesters.
// A request/done handshake replaces the old mclk-phase address mux. mem_ready
// provides wait states, and a bus timeout aborts an access the memory never finishes.
// Priority is ls > if > dbg. A dbg request that keeps losing grants is
// promoted to top priority after DBG_STARVE_MAX lost grants.
// Optional build macro HYPERCPU_MEM_ARB_STATS_EN adds saturating grant and
// wait-cycle counters. Without it those ports do not exist.
module hypercpu_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DBG_STARVE_MAX = 8,
  parameter int TIMEOUT        = 16
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write,
  output logic              mem_write_enable,
  output logic              mem_valid,
  input  logic [DATA_W-1:0] mem_read,
  input  logic              mem_ready,
  output logic              timeout_err
`ifdef HYPERCPU_MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_ls_grants,
  output logic [31:0]       stat_dbg_grants,
  output logic [31:0]       stat_wait_cycles
`endif
);

  // Requester index used for the one-hot grant/owner vectors
  localparam int P_IF  = 0;
  localparam int P_LS  = 1;
  localparam int P_DBG = 2;

  localparam logic [7:0]         C_STARVE_MAX = 8'(DBG_STARVE_MAX);
  localparam logic [15:0]        C_TMO_LAST   = 16'(TIMEOUT - 1);
  // Abort pattern, zero-extended or truncated to the data width
  localparam logic [DATA_W+31:0] C_DEAD_EXT   = {{DATA_W{1'b0}}, 32'hDEADBEEF};
  localparam logic [DATA_W-1:0]  C_DEAD       = C_DEAD_EXT[DATA_W-1:0];

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [2:0]                 w_req;
  logic [2:0]                 w_grant;
  logic [2:0]                 r_owner;
  logic                       w_finish;
  logic                       w_abort;
  logic [ADDR_W-1:0]          w_sel_addr;
  logic [DATA_W-1:0]          w_sel_wdata;
  logic                       w_sel_we;
  logic [ADDR_W-1:0]          r_mem_addr;
  logic [DATA_W-1:0]          r_mem_write;
  logic                       r_mem_we;
  logic                       r_mem_valid;
  logic [7:0]                 r_starve_cnt;
  logic [15:0]                r_tmo_cnt;
  logic                       r_timeout_err;
  logic [2:0]                 w_done;
  logic [2:0][DATA_W-1:0]     w_rdata;

  genvar gi;

  assign w_req = {dbg_req, ls_req, if_req};

  // State register
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, arbitration winner and completion/abort decode
  always_comb begin
    w_state_next = r_state;
    w_grant      = 3'b000;
    w_finish     = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_state_next = S_ACCESS;
          if (dbg_req && (r_starve_cnt == C_STARVE_MAX)) begin
            w_grant[P_DBG] = 1'b1;
          end else if (ls_req) begin
            w_grant[P_LS] = 1'b1;
          end else if (if_req) begin
            w_grant[P_IF] = 1'b1;
          end else begin
            w_grant[P_DBG] = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        // mem_ready takes precedence over a timeout in the same cycle
        if (mem_ready) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_tmo_cnt == C_TMO_LAST) begin
          w_finish     = 1'b1;
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Select the winner's request fields. Fetch never writes.
  always_comb begin
    w_sel_addr  = if_addr;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    if (w_grant[P_LS]) begin
      w_sel_addr  = ls_addr;
      w_sel_wdata = ls_wdata;
      w_sel_we    = ls_we;
    end else if (w_grant[P_DBG]) begin
      w_sel_addr  = dbg_addr;
      w_sel_wdata = dbg_wdata;
      w_sel_we    = dbg_we;
    end
  end

  // Bus register: load at grant, hold through ACCESS, drop strobes on finish
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_mem_addr  <= '0;
      r_mem_write <= '0;
      r_mem_we    <= 1'b0;
      r_mem_valid <= 1'b0;
      r_owner     <= 3'b000;
      r_tmo_cnt   <= '0;
    end else if (|w_grant) begin
      r_mem_addr  <= w_sel_addr;
      r_mem_write <= w_sel_wdata;
      r_mem_we    <= w_sel_we;
      r_mem_valid <= 1'b1;
      r_owner     <= w_grant;
      r_tmo_cnt   <= '0;
    end else if (w_finish) begin
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // Count grants that dbg loses while it is waiting. A dbg grant or an idle dbg clears the count.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (!dbg_req || w_grant[P_DBG]) begin
        r_starve_cnt <= '0;
      end else if ((w_grant[P_LS] || w_grant[P_IF]) && (r_starve_cnt != C_STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_abort) begin
      r_timeout_err <= 1'b1;
    end
  end

  // Per-requester completion pulse and held read data
  for (gi = 0; gi < 3; gi++) begin : g_port
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;

    // Pulse done for the owner on completion and capture its read data
    always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
        r_done  <= 1'b0;
        r_rdata <= '0;
      end else begin
        r_done <= w_finish & r_owner[gi];
        if (w_finish && r_owner[gi]) begin
          if (w_abort) begin
            r_rdata <= C_DEAD;
          end else if (r_mem_we) begin
            r_rdata <= '0;
          end else begin
            r_rdata <= mem_read;
          end
        end
      end
    end

    assign w_done[gi]  = r_done;
    assign w_rdata[gi] = r_rdata;
  end

  assign if_done          = w_done[P_IF];
  assign ls_done          = w_done[P_LS];
  assign dbg_done         = w_done[P_DBG];
  assign if_rdata         = w_rdata[P_IF];
  assign ls_rdata         = w_rdata[P_LS];
  assign dbg_rdata        = w_rdata[P_DBG];
  assign mem_addr         = r_mem_addr;
  assign mem_write        = r_mem_write;
  assign mem_write_enable = r_mem_we;
  assign mem_valid        = r_mem_valid;
  assign timeout_err      = r_timeout_err;

`ifdef HYPERCPU_MEM_ARB_STATS_EN
  logic [3:0]       w_stat_inc;
  logic [3:0][31:0] w_stat_cnt;

  assign w_stat_inc = {(r_state == S_ACCESS) && !mem_ready,
                       w_grant[P_DBG], w_grant[P_LS], w_grant[P_IF]};

  for (gi = 0; gi < 4; gi++) begin : g_stat
    logic [31:0] r_cnt;

    // Saturating event counter
    always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (w_stat_inc[gi] && (r_cnt != 32'hFFFF_FFFF)) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end

    assign w_stat_cnt[gi] = r_cnt;
  end

  assign stat_if_grants   = w_stat_cnt[0];
  assign stat_ls_grants   = w_stat_cnt[1];
  assign stat_dbg_grants  = w_stat_cnt[2];
  assign stat_wait_cycles = w_stat_cnt[3];
`endif

endmodule

// File: tb/tb_hypercpu_mem_arbiter.sv
// Testbench for hypercpu_mem_arbiter. It runs directed scenarios first and
// then randomized requesters and memory wait states. Every cycle the DUT is
// compared against a transaction-level reference model.
module tb_hypercpu_mem_arbiter;

  localparam int TB_STARVE  = 2;
  localparam int TB_TIMEOUT = 4;

  logic        mclk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  t_req = 3'b000;
  logic [2:0]  t_we = 3'b000;
  logic [31:0] t_addr [3];
  logic [31:0] t_wdata [3];
  logic        t_mem_ready = 1'b0;
  logic [31:0] t_mem_read = 32'h0;

  logic [31:0] if_rdata, ls_rdata, dbg_rdata;
  logic        if_done, ls_done, dbg_done;
  logic [31:0] mem_addr, mem_write;
  logic        mem_write_enable, mem_valid, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (transaction level)
  bit          m_busy;
  int          m_owner;
  int          m_n;
  int          m_starve;
  bit          m_we;
  bit          m_err;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata [3];
  bit   [2:0]  m_done;

  hypercpu_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .DBG_STARVE_MAX(TB_STARVE), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .mclk(mclk), .reset(reset),
    .if_req(t_req[0]), .if_addr(t_addr[0]), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(t_req[1]), .ls_we(t_we[1]), .ls_addr(t_addr[1]), .ls_wdata(t_wdata[1]),
    .ls_rdata(ls_rdata), .ls_done(ls_done),
    .dbg_req(t_req[2]), .dbg_we(t_we[2]), .dbg_addr(t_addr[2]), .dbg_wdata(t_wdata[2]),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_write_enable(mem_write_enable),
    .mem_valid(mem_valid), .mem_read(t_mem_read), .mem_ready(t_mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 mclk = ~mclk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_n = 0; m_starve = 0; m_we = 0; m_err = 0;
    m_addr = 32'h0; m_wdata = 32'h0; m_done = 3'b000;
    for (int p = 0; p < 3; p++) m_rdata[p] = 32'h0;
  endtask

  // Advance the model by one cycle using the inputs presented this cycle
  task automatic model_step();
    bit [2:0] nd;
    int w;
    nd = 3'b000;
    if (m_busy) begin
      if (t_mem_ready) begin
        nd[m_owner] = 1'b1;
        m_rdata[m_owner] = m_we ? 32'h0 : t_mem_read;
        m_busy = 0;
      end else if (m_n == TB_TIMEOUT) begin
        nd[m_owner] = 1'b1;
        m_rdata[m_owner] = 32'hDEADBEEF;
        m_err = 1;
        m_busy = 0;
      end else begin
        m_n++;
      end
    end else begin
      if (!t_req[2]) m_starve = 0;
      if (t_req != 3'b000) begin
        if (t_req[2] && m_starve == TB_STARVE) w = 2;
        else if (t_req[1]) w = 1;
        else if (t_req[0]) w = 0;
        else w = 2;
        if (w == 2) m_starve = 0;
        else if (t_req[2] && m_starve < TB_STARVE) m_starve++;
        m_owner = w;
        m_addr  = t_addr[w];
        m_we    = (w == 0) ? 1'b0 : t_we[w];
        m_wdata = (w == 0) ? 32'h0 : t_wdata[w];
        m_busy  = 1;
        m_n     = 1;
      end
    end
    m_done = nd;
  endtask

  task automatic compare_outputs();
    logic [31:0] d_rdata [3];
    logic [2:0]  d_done;
    d_rdata[0] = if_rdata; d_rdata[1] = ls_rdata; d_rdata[2] = dbg_rdata;
    d_done = {dbg_done, ls_done, if_done};
    check_value("mem_valid", 32'(mem_valid), 32'(m_busy));
    check_value("mem_we", 32'(mem_write_enable), 32'(m_busy && m_we));
    check_value("mem_addr", mem_addr, m_addr);
    check_value("mem_write", mem_write, m_wdata);
    check_value("timeout_err", 32'(timeout_err), 32'(m_err));
    for (int p = 0; p < 3; p++) begin
      check_value($sformatf("done_%0d", p), 32'(d_done[p]), 32'(m_done[p]));
      check_value($sformatf("rdata_%0d", p), d_rdata[p], m_rdata[p]);
      if (m_done[p])
        $display("txn port=%0d addr=%08h we=%0d rdata=%08h err=%0d t=%0t",
                 p, m_addr, m_we, m_rdata[p], m_err, $time);
    end
  endtask

  // One clock: predict, let the DUT clock, then compare on the falling edge
  task automatic step();
    model_step();
    @(posedge mclk);
    @(negedge mclk);
    compare_outputs();
  endtask

  task automatic new_request(input int p);
    t_req[p]   = 1'b1;
    t_addr[p]  = $urandom;
    t_wdata[p] = $urandom;
    t_we[p]    = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      t_addr[p] = 32'h0;
      t_wdata[p] = 32'h0;
    end
    model_reset();

    // Reset: every output low
    reset = 1'b0;
    repeat (2) @(negedge mclk);
    compare_outputs();
    check_value("rst_valid", 32'(mem_valid), 32'h0);
    check_value("rst_addr", mem_addr, 32'h0);
    reset = 1'b1;

    // Zero-wait fetch
    t_req[0] = 1'b1; t_addr[0] = 32'h10; t_mem_ready = 1'b1; t_mem_read = 32'hA5A5A5A5;
    step();
    check_value("fetch_valid_c1", 32'(mem_valid), 32'h1);
    check_value("fetch_addr_c1", mem_addr, 32'h10);
    step();
    check_value("fetch_done_c2", 32'(if_done), 32'h1);
    check_value("fetch_rdata_c2", if_rdata, 32'hA5A5A5A5);
    t_req[0] = 1'b0;
    step();

    // Contention: ls wins, if is served from the ls done cycle
    t_req = 3'b011; t_addr[1] = 32'h200; t_we[1] = 1'b0; t_wdata[1] = 32'h0;
    t_addr[0] = 32'h300; t_mem_read = 32'h11112222;
    step();
    check_value("cont_addr_c1", mem_addr, 32'h200);
    step();
    check_value("cont_ls_done_c2", 32'(ls_done), 32'h1);
    check_value("cont_if_wait_c2", 32'(if_done), 32'h0);
    t_req[1] = 1'b0; t_mem_read = 32'h33334444;
    step();
    check_value("cont_addr_c3", mem_addr, 32'h300);
    step();
    check_value("cont_if_done_c4", 32'(if_done), 32'h1);
    check_value("cont_if_rdata_c4", if_rdata, 32'h33334444);
    t_req[0] = 1'b0;
    step();

    // dbg store with 3 wait states; ready lands in the last pre-timeout cycle
    t_req[2] = 1'b1; t_we[2] = 1'b1; t_addr[2] = 32'h40; t_wdata[2] = 32'h1234;
    t_mem_ready = 1'b0; t_mem_read = 32'hFFFF0000;
    step();
    t_addr[2] = 32'h99; t_wdata[2] = 32'h5555;
    for (int c = 1; c <= 4; c++) begin
      check_value($sformatf("store_we_c%0d", c), 32'(mem_write_enable), 32'h1);
      check_value($sformatf("store_data_c%0d", c), mem_write, 32'h1234);
      t_mem_ready = (c == 4);
      step();
    end
    check_value("store_done", 32'(dbg_done), 32'h1);
    check_value("store_rdata", dbg_rdata, 32'h0);
    check_value("store_no_err", 32'(timeout_err), 32'h0);
    t_req[2] = 1'b0; t_mem_ready = 1'b1;
    step();

    // Starvation: dbg promoted at the third arbitration, then counter cleared
    t_req = 3'b111; t_we = 3'b000;
    t_addr[0] = 32'h300; t_addr[1] = 32'h200; t_addr[2] = 32'h600;
    t_mem_read = 32'h0BADF00D;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 5)  check_value("starve_dbg_addr_c5", mem_addr, 32'h600);
      if (c == 6)  check_value("starve_dbg_done_c6", 32'(dbg_done), 32'h1);
      if (c == 7)  check_value("starve_ls_addr_c7", mem_addr, 32'h200);
      if (c == 11) check_value("starve_dbg_addr_c11", mem_addr, 32'h600);
    end
    t_req = 3'b000;
    step();
    step();

    // Timeout on a load
    t_req[1] = 1'b1; t_we[1] = 1'b0; t_addr[1] = 32'h500; t_mem_ready = 1'b0;
    step();
    for (int c = 1; c <= 4; c++) step();
    check_value("tmo_done", 32'(ls_done), 32'h1);
    check_value("tmo_rdata", ls_rdata, 32'hDEADBEEF);
    check_value("tmo_err", 32'(timeout_err), 32'h1);
    t_req[1] = 1'b0; t_mem_ready = 1'b1;
    repeat (3) step();
    check_value("tmo_err_sticky", 32'(timeout_err), 32'h1);

    // Reset in the middle of a waited access
    t_req[0] = 1'b1; t_addr[0] = 32'h700; t_mem_ready = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    check_value("midrst_valid", 32'(mem_valid), 32'h0);
    check_value("midrst_done", 32'(if_done), 32'h0);
    check_value("midrst_err", 32'(timeout_err), 32'h0);
    t_req = 3'b000;
    model_reset();
    @(negedge mclk);
    compare_outputs();
    reset = 1'b1;
    t_req[0] = 1'b1; t_addr[0] = 32'h20; t_mem_ready = 1'b1; t_mem_read = 32'hCAFE0001;
    step();
    step();
    check_value("midrst_next_done", 32'(if_done), 32'h1);
    check_value("midrst_next_rdata", if_rdata, 32'hCAFE0001);
    t_req[0] = 1'b0;
    step();

    // Randomized requesters and memory
    for (int c = 0; c < 2500; c++) begin
      t_mem_ready = ($urandom_range(0, 99) < 65);
      t_mem_read  = $urandom;
      step();
      for (int p = 0; p < 3; p++) begin
        if (m_done[p]) begin
          if ($urandom_range(0, 1) == 1) new_request(p);
          else t_req[p] = 1'b0;
        end else if (m_busy && m_owner == p) begin
          // Fields may change once granted; occasionally drop req mid-access
          t_addr[p]  = $urandom;
          t_wdata[p] = $urandom;
          if (p != 0) t_we[p] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 9) == 0) t_req[p] = 1'b0;
        end else if (!t_req[p] && $urandom_range(0, 3) == 0) begin
          new_request(p);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
